// File: rtl/seq_restoring_divider_pkg.sv
// Shared widths, counter sizing and FSM state encoding for the restoring divider.
package div_pkg;

   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;
   localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface seq_restoring_divider_if;
   import div_pkg::*;

   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
   import div_pkg::*;
(
   input  logic [DIVISOR_W-1:0] prem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W-1:0] prem_o,
   output logic                 qbit_o
);

   logic [DIVISOR_W:0]   shifted;
   logic [DIVISOR_W-1:0] diffLow;

   // The incoming remainder is always below the divisor, so the shifted value
   // needs one extra bit for the compare but the difference fits in DIVISOR_W.
   assign shifted = {prem_i, bit_i};
   assign qbit_o  = (shifted >= {1'b0, divisor_i});
   assign diffLow = shifted[DIVISOR_W-1:0] - divisor_i;
   assign prem_o  = qbit_o ? diffLow : shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done framed.
module seq_restoring_divider
   import div_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   seq_restoring_divider_if.slave  bus
);

   div_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVISOR_W-1:0]  prem_q, prem_d;
   logic [DIVIDEND_W-1:0] dividendShift_q, dividendShift_d;
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   logic [DIVIDEND_W-1:0] quotientAcc_q, quotientAcc_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  divByZero_q, divByZero_d;

   logic [DIVISOR_W-1:0]  stepPrem;
   logic                  stepQbit;
   logic                  lastIter;

   div_step u_step (
      .prem_i    (prem_q),
      .bit_i     (dividendShift_q[DIVIDEND_W-1]),
      .divisor_i (divisor_q),
      .prem_o    (stepPrem),
      .qbit_o    (stepQbit)
   );

   assign lastIter = (cnt_q == CNT_W'(DIVIDEND_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         prem_q          <= '0;
         dividendShift_q <= '0;
         divisor_q       <= '0;
         quotientAcc_q   <= '0;
         quotient_q      <= '0;
         remainder_q     <= '0;
         divByZero_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         prem_q          <= prem_d;
         dividendShift_q <= dividendShift_d;
         divisor_q       <= divisor_d;
         quotientAcc_q   <= quotientAcc_d;
         quotient_q      <= quotient_d;
         remainder_q     <= remainder_d;
         divByZero_q     <= divByZero_d;
      end
   end

   // A new operation may be accepted from IDLE or DONE, which is what makes
   // back-to-back operation possible without an idle bubble.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      prem_d          = prem_q;
      dividendShift_d = dividendShift_q;
      divisor_d       = divisor_q;
      quotientAcc_d   = quotientAcc_q;
      quotient_d      = quotient_q;
      remainder_d     = remainder_q;
      divByZero_d     = divByZero_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               dividendShift_d = bus.dividend;
               divisor_d       = bus.divisor;
               quotient_d      = '0;
               remainder_d     = '0;
               divByZero_d     = 1'b0;
               if (bus.divisor == '0) begin
                  quotient_d  = '1;
                  divByZero_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  prem_d        = '0;
                  cnt_d         = '0;
                  quotientAcc_d = '0;
                  state_d       = CALC;
               end
            end
         end

         CALC: begin
            dividendShift_d = {dividendShift_q[DIVIDEND_W-2:0], 1'b0};
            prem_d          = stepPrem;
            quotientAcc_d   = {quotientAcc_q[DIVIDEND_W-2:0], stepQbit};
            cnt_d           = cnt_q + CNT_W'(1);
            if (lastIter) begin
               quotient_d  = {quotientAcc_q[DIVIDEND_W-2:0], stepQbit};
               remainder_d = stepPrem;
               state_d     = DONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.busy        = (state_q == CALC);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed cases, round-trip products and random traffic.
module tb_seq_restoring_divider;
   import div_pkg::*;

   typedef struct {
      logic [DIVIDEND_W-1:0] dd;
      logic [DIVISOR_W-1:0]  dv;
      logic [DIVIDEND_W-1:0] q;
      logic [DIVISOR_W-1:0]  r;
      logic                  dbz;
   } exp_t;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;
   exp_t sb[$];

   seq_restoring_divider_if dif ();

   seq_restoring_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, with the all-ones/zero/flag convention for divisor zero.
   function automatic exp_t refModel(input logic [DIVIDEND_W-1:0] dd, input logic [DIVISOR_W-1:0] dv);
      exp_t e;
      int   a;
      int   b;
      a     = int'(dd);
      b     = int'(dv);
      e.dd  = dd;
      e.dv  = dv;
      if (b == 0) begin
         e.q   = '1;
         e.r   = '0;
         e.dbz = 1'b1;
      end else begin
         e.q   = DIVIDEND_W'(a / b);
         e.r   = DIVISOR_W'(a % b);
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " busy"},        int'(dif.busy),        0);
      checkOutput({tag, " done"},        int'(dif.done),        0);
      checkOutput({tag, " quotient"},    int'(dif.quotient),    0);
      checkOutput({tag, " remainder"},   int'(dif.remainder),   0);
      checkOutput({tag, " div_by_zero"}, int'(dif.div_by_zero), 0);
   endtask

   // Called just after a falling edge; start is sampled on the following rising edge.
   task automatic applyStimulus(input logic [DIVIDEND_W-1:0] dd, input logic [DIVISOR_W-1:0] dv);
      dif.dividend = dd;
      dif.divisor  = dv;
      dif.start    = 1'b1;
      sb.push_back(refModel(dd, dv));
      @(posedge clk);
      #1;
      dif.start = 1'b0;
   endtask

   task automatic waitDone(output int lat, output int busyCycles);
      lat        = 0;
      busyCycles = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (dif.busy) busyCycles++;
         if (dif.done) break;
      end
      if (!dif.done) checkOutput("done timeout", 0, 1);
   endtask

   task automatic runOp(input logic [DIVIDEND_W-1:0] dd, input logic [DIVISOR_W-1:0] dv);
      int lat;
      int bc;
      applyStimulus(dd, dv);
      waitDone(lat, bc);
      checkOutput($sformatf("latency %0d/%0d", dd, dv), lat, (dv == 0) ? 1 : DIVIDEND_W + 1);
      checkOutput($sformatf("busy cycles %0d/%0d", dd, dv), bc, (dv == 0) ? 0 : DIVIDEND_W);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dif.done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected done", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput($sformatf("quotient %0d/%0d", e.dd, e.dv), int'(dif.quotient), int'(e.q));
            checkOutput($sformatf("remainder %0d/%0d", e.dd, e.dv), int'(dif.remainder), int'(e.r));
            checkOutput($sformatf("div_by_zero %0d/%0d", e.dd, e.dv), int'(dif.div_by_zero), int'(e.dbz));
            checkOutput($sformatf("busy with done %0d/%0d", e.dd, e.dv), int'(dif.busy), 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int bc;
      logic [DIVIDEND_W-1:0] dd;
      logic [DIVISOR_W-1:0]  dv;

      compared     = 0;
      mismatched   = 0;
      dif.start    = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      rst_n        = 1'b1;
      #2 rst_n = 1'b0;
      #1 checkResetOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed cases");
      runOp(8'd200, 4'd7);
      repeat (2) @(negedge clk);
      checkOutput("hold quotient in idle", int'(dif.quotient), 28);
      checkOutput("hold remainder in idle", int'(dif.remainder), 4);
      runOp(8'd255, 4'd1);
      runOp(8'd0, 4'd5);
      runOp(8'd15, 4'd15);
      runOp(8'd100, 4'd0);
      @(negedge clk);

      $display("[TB] start during CALC, then back-to-back");
      applyStimulus(8'd200, 4'd7);
      repeat (3) @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 8'd99;
      dif.divisor  = 4'd4;
      waitDone(lat, bc);
      checkOutput("latency with ignored start", lat, DIVIDEND_W - 2);
      applyStimulus(8'd99, 4'd4);
      waitDone(lat, bc);
      checkOutput("latency back-to-back", lat, DIVIDEND_W + 1);
      @(negedge clk);

      $display("[TB] reset mid-operation");
      applyStimulus(8'd200, 4'd7);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1 checkResetOutputs("mid-op reset");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      runOp(8'd50, 4'd6);

      $display("[TB] round-trip products");
      for (int a = 1; a <= 15; a++) begin
         for (int b = 1; b <= 15; b++) begin
            runOp(DIVIDEND_W'(a * b), DIVISOR_W'(b));
         end
      end

      $display("[TB] random traffic");
      for (int i = 0; i < 200; i++) begin
         dd = DIVIDEND_W'($urandom_range(0, 255));
         dv = ($urandom_range(0, 9) == 0) ? '0 : DIVISOR_W'($urandom_range(1, 15));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         runOp(dd, dv);
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
